uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Command/program loader directly downstream of the 32-bit UART word receiver.
- Consumes the receiver's assembled words and end-of-word pulse.
- Drives the receiver's single-byte mode input to alternate between 1-byte commands and 32-bit payload words.
- Writes payload words into CPU instruction/data memory and holds or releases the CPU reset.

Parameters:
ADDR_W, 10, width of the word address to memory; addresses wrap modulo 2^ADDR_W
TIMEOUT_CYCLES, 10_000_000, max clk cycles between words inside a transfer before abort (1 s at 10 MHz)

Ports:
clk  input  1  system clock (10 MHz)
reset  input  1  active-low asynchronous reset
word_in  input  32  assembled word from the receiver; byte 1 received is bits [7:0]
word_valid  input  1  one-cycle pulse, word_in valid this cycle
one_byte  output  1  to receiver: 1 = next item is a single command byte, 0 = 4-byte word
mem_we  output  1  one-cycle memory write strobe
mem_addr  output  ADDR_W  word address for the write
mem_wdata  output  32  write data
cpu_reset  output  1  active-high CPU hold; 1 while loading or halted
busy  output  1  1 while a load transfer is in progress
error  output  1  sticky fault flag

Behaviour:
- Reset (async, reset=0): state CMD, one_byte=1, cpu_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, error=0, counters=0.
- All outputs are registered.
- one_byte changes only in the cycle after an accepted word_valid, so it is stable before the receiver's next first byte is saved.
- States and transitions:
  - CMD (one_byte=1): on word_valid, decode word_in[7:0].
    - 0x4C 'L': cpu_reset=1, busy=1, error=0, one_byte=0, go to ADDR.
    - 0x52 'R': cpu_reset=0, error=0, stay in CMD.
    - 0x48 'H': cpu_reset=1, error=0, stay in CMD.
    - Any other byte: error=1, stay in CMD, cpu_reset unchanged.
  - ADDR: on word_valid, base = word_in[ADDR_W-1:0], go to COUNT.
  - COUNT: on word_valid, remaining = word_in (32-bit), index = 0.
    - If word_in==0: go to CMD, busy=0, one_byte=1, no writes.
    - Otherwise go to DATA.
  - DATA: on word_valid:
    - Next cycle: mem_we=1, mem_addr=base+index (ADDR_W-bit wrap), mem_wdata=word_in. Latency is exactly 1 cycle.
    - index increments and remaining decrements.
    - When remaining reaches 0: go to CMD (or CSUM if enabled), one_byte=1 (0 if CSUM), busy=0 unless CSUM.
  - cpu_reset stays 1 after a load; only 'R' releases it.
- Timeout: a counter clears on every word_valid and runs in ADDR/COUNT/DATA/CSUM.
  - On reaching TIMEOUT_CYCLES-1: error=1, busy=0, one_byte=1, go to CMD.
  - Writes already issued are not undone.
- word_valid in the same cycle as the timeout expiry: the word wins and the counter clears.
- mem_we is never asserted outside DATA-originated writes and is never high two consecutive cycles.
- Async reset mid-transfer: immediate return to reset values; any pending write is dropped.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: adds state CSUM after the last DATA word.
  - Running sum = 32-bit wrapping sum of all data words in the transfer.
  - The next word is compared against the sum. Mismatch: error=1. Match: error unchanged (0).
  - Then one_byte=1, busy=0, go to CMD.
- Undefined: no CSUM state and no sum register; DATA returns directly to CMD.

Decomposition:
- Package uart_loader_pkg:
  - State encoding localparams: CMD, ADDR, COUNT, DATA, CSUM.
  - Command byte constants: CMD_LOAD=8'h4C, CMD_RUN=8'h52, CMD_HALT=8'h48.
- No sub-module needed. The block is instantiated beside uart_32bit_rx in the top level: one_byte connects to its one_byte input, and data_out/data_end connect to word_in/word_valid.

Test Plan:
- Reset released, idle 100 cycles -> cpu_reset=1, one_byte=1, mem_we never high, error=0.
- Command 'L', base 0x10, count 3, words 0xDEADBEEF, 0x00000001, 0xCAFEF00D -> three mem_we pulses, each 1 cycle after word_valid, at addr 0x10/0x11/0x12 with matching data. busy falls after the last word, one_byte=1, cpu_reset=1. Then 'R' -> cpu_reset=0.
- Command 'L', base 0x3FF, count 2 (ADDR_W=10) -> writes at 0x3FF then 0x000.
- Byte 0x55 in CMD -> error=1, state stays CMD. Then 'H' -> error=0, cpu_reset=1.
- 'L', base 0, count 5, only 2 data words, then silence with TIMEOUT_CYCLES=1000 -> error=1 at cycle 1000 after the last word, busy=0, one_byte=1, only 2 writes issued.
- With LOADER_CHECKSUM_EN: 'L', base 0, count 2, data 0xFFFFFFFF and 0x00000002, checksum 0x00000001 -> error=0. Repeat with checksum 0x00000002 -> error=1.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and
// the single-byte command codes understood in the command state.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM state.
package uart_loader_pkg;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        CMD   = 3'd0,
        ADDR  = 3'd1,
        COUNT = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        CMD   = 3'd0,
        ADDR  = 3'd1,
        COUNT = 3'd2,
        DATA  = 3'd3
    } loader_state_t;
`endif

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

endpackage

// File: rtl/uart_prog_loader.sv
// Command/program loader sitting behind the 32-bit UART word receiver.
// Accepts 1-byte commands (L/R/H), and for 'L' a base address, a word count
// and that many data words which are written to CPU memory one cycle after
// each word arrives. Holds the CPU in reset until 'R'.
// Optional feature macro: LOADER_CHECKSUM_EN appends a checksum word that
// must equal the 32-bit wrapping sum of the data words.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    output logic              one_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    loader_state_t     state_reg, state_next;
    logic              one_byte_reg, one_byte_next;
    logic              cpu_reset_reg, cpu_reset_next;
    logic              busy_reg, busy_next;
    logic              error_reg, error_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [31:0]       remaining_reg, remaining_next;
    logic [31:0]       timer_reg, timer_next;
    logic              timeout_hit;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum_reg, sum_next;
`endif

    assign one_byte  = one_byte_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_reset = cpu_reset_reg;
    assign busy      = busy_reg;
    assign error     = error_reg;

    // A waiting word always beats the timeout; the timer only runs mid-transfer.
    assign timeout_hit = (state_reg != CMD) && !word_valid && (timer_reg == TIMEOUT_LAST);

    // State and output registers; async reset drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= CMD;
            one_byte_reg  <= 1'b1;
            cpu_reset_reg <= 1'b1;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            base_reg      <= '0;
            index_reg     <= '0;
            remaining_reg <= '0;
            timer_reg     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            one_byte_reg  <= one_byte_next;
            cpu_reset_reg <= cpu_reset_next;
            busy_reg      <= busy_next;
            error_reg     <= error_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            base_reg      <= base_next;
            index_reg     <= index_next;
            remaining_reg <= remaining_next;
            timer_reg     <= timer_next;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= sum_next;
`endif
        end
    end

    // Next-state and next-output decode for the command/transfer sequence.
    always_comb begin
        state_next     = state_reg;
        one_byte_next  = one_byte_reg;
        cpu_reset_next = cpu_reset_reg;
        busy_next      = busy_reg;
        error_next     = error_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        base_next      = base_reg;
        index_next     = index_reg;
        remaining_next = remaining_reg;
        timer_next     = (state_reg == CMD || word_valid) ? 32'd0 : timer_reg + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_next       = sum_reg;
`endif

        if (timeout_hit) begin
            // Abandon the transfer; writes already made stay in memory.
            error_next    = 1'b1;
            busy_next     = 1'b0;
            one_byte_next = 1'b1;
            state_next    = CMD;
            timer_next    = 32'd0;
        end else if (word_valid) begin
            case (state_reg)
                CMD: begin
                    case (word_in[7:0])
                        CMD_LOAD: begin
                            cpu_reset_next = 1'b1;
                            busy_next      = 1'b1;
                            error_next     = 1'b0;
                            one_byte_next  = 1'b0;
                            state_next     = ADDR;
                        end
                        CMD_RUN: begin
                            cpu_reset_next = 1'b0;
                            error_next     = 1'b0;
                        end
                        CMD_HALT: begin
                            cpu_reset_next = 1'b1;
                            error_next     = 1'b0;
                        end
                        default: error_next = 1'b1;
                    endcase
                end
                ADDR: begin
                    base_next  = word_in[ADDR_W-1:0];
                    state_next = COUNT;
                end
                COUNT: begin
                    remaining_next = word_in;
                    index_next     = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_next       = '0;
`endif
                    if (word_in == 32'd0) begin
                        // Empty load: nothing to write, back to commands.
                        busy_next     = 1'b0;
                        one_byte_next = 1'b1;
                        state_next    = CMD;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    we_next        = 1'b1;
                    addr_next      = base_reg + index_reg;
                    wdata_next     = word_in;
                    index_next     = index_reg + 1'b1;
                    remaining_next = remaining_reg - 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_next       = sum_reg + word_in;
                    if (remaining_reg == 32'd1) begin
                        state_next = CSUM;
                    end
`else
                    if (remaining_reg == 32'd1) begin
                        busy_next     = 1'b0;
                        one_byte_next = 1'b1;
                        state_next    = CMD;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (word_in != sum_reg) begin
                        error_next = 1'b1;
                    end
                    busy_next     = 1'b0;
                    one_byte_next = 1'b1;
                    state_next    = CMD;
                end
`endif
                default: begin
                    one_byte_next = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = CMD;
                end
            endcase
        end
    end

endmodule
